divider_seq: RTL and testbench
==============================

# divider_seq

Parametrised multi-cycle integer divider that replaces the single-cycle `/` and `%` path on the ALU's DIV operation with a restoring shift-subtract engine producing one quotient bit per clock. It supports signed and unsigned modes, flags divide-by-zero, and uses a start/busy/done handshake so the control unit can stall while the divide runs. Its `{remainder, quotient}` result drops directly into the 64-bit Z register path (HI = remainder, LO = quotient).

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width. Must be at least 4.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a divide. Sampled only when `busy` = 0.
- `signed_mode` in 1: 1 = two's-complement divide, 0 = unsigned. Latched with `start`.
- `dividend` in WIDTH: Q operand. Latched with `start`.
- `divisor` in WIDTH: M operand. Latched with `start`.
- `busy` out 1: high from the cycle after `start` is accepted through FIXUP.
- `done` out 1: one-cycle pulse; results are valid in that cycle.
- `div_by_zero` out 1: valid with `done`; held until the next accepted `start`.
- `quotient` out WIDTH: held until the next accepted `start`.
- `remainder` out WIDTH: held until the next accepted `start`.

## Operation
- FSM states are IDLE, PREP, ITER, FIXUP and DONE.
- **IDLE / DONE**
  - `busy` = 0.
  - On `start`, latch the operands and mode, then go to PREP.
  - DONE with no `start` returns to IDLE.
- **PREP** (1 cycle)
  - Take absolute values when `signed_mode` = 1.
  - Record `q_neg = sign(dividend) ^ sign(divisor)` and `r_neg = sign(dividend)`.
  - Clear the partial remainder and set the iteration counter to WIDTH-1.
  - If `divisor` = 0, go to FIXUP. Otherwise go to ITER.
- **ITER** (exactly WIDTH cycles)
  - Shift {R, Q} left by 1.
  - Compute a trial `R - |M|` in WIDTH+1 bits.
  - If the trial is non-negative, R takes the trial value and Q[0] = 1. Otherwise R is kept and Q[0] = 0.
  - Decrement the counter. Go to FIXUP when the counter reaches 0.
- **FIXUP** (1 cycle)
  - Negate Q if `q_neg`. Negate R if `r_neg`.
  - For divide-by-zero: `quotient` = all ones, `remainder` = original `dividend`, `div_by_zero` = 1.
  - Go to DONE.
- **Arithmetic rules**
  - Signed results truncate toward zero: the remainder takes the dividend's sign, and |remainder| < |divisor|.
  - MIN / -1 wraps: `quotient` = MIN, `remainder` = 0, no flag.
- **Handshake and reset**
  - `start` while `busy` = 1 is ignored, with no queueing.
  - `reset` in any state forces IDLE on the next edge, aborting any divide in flight.
  - Reset values: `busy` = 0, `done` = 0, `div_by_zero` = 0, `quotient` = 0, `remainder` = 0.

## Timing
- `start` is sampled at edge k.
- Normal divide:
  - PREP runs in cycle k+1.
  - ITER runs in cycles k+2 .. k+WIDTH+1.
  - FIXUP runs in cycle k+WIDTH+2.
  - `done` is high in cycle k+WIDTH+3.
- Latency is WIDTH+3 cycles; 35 cycles at WIDTH = 32.
- Divide-by-zero: `done` is high in cycle k+3.
- Back-to-back: `start` asserted in the `done` cycle is accepted, so throughput is one divide every WIDTH+3 cycles.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - the state enum;
  - the ALU op index constants (ADD = 0 … DIV = 4 … INC = 13), so ALU and control decode agree;
  - the default WIDTH = 32.
- Sub-module `div_step`: combinational, one iteration. Inputs are R, Q and |M|; outputs are the next R and Q. It is instantiated once in ITER.
- The FSM, counter (clog2(WIDTH) bits) and sign fixup live in `divider_seq`.

## Test plan
- Unsigned, WIDTH = 32: 20 / 5 → `quotient` = 4, `remainder` = 0, `done` exactly 35 cycles after `start`, `busy` high for 34 cycles.
- Signed sign combinations: -7 / 2 → q = -3, r = -1; 7 / -2 → q = -3, r = 1; -7 / -2 → q = 3, r = -1. Unsigned 0xFFFFFFF9 / 2 → q = 0x7FFFFFFC, r = 1.
- Divide-by-zero: 13 / 0 → `div_by_zero` = 1, `quotient` = 0xFFFFFFFF, `remainder` = 13, `done` 3 cycles after `start`.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → `quotient` = 0x80000000, `remainder` = 0, `div_by_zero` = 0.
- Handshake and reset:
  - Pulse `start` with new operands mid-ITER → ignored; the original result completes.
  - Assert `reset` mid-ITER → next cycle `busy` = 0 and all outputs are 0, and no `done` appears.
  - A `start` in the `done` cycle is accepted.
- Parameter sweep: WIDTH = 8, unsigned 200 / 7 → q = 28, r = 4, `done` 11 cycles after `start`. Random signed/unsigned operands are checked against a reference model.

Source files
------------

// File: rtl/divider_seq_pkg.sv
// Shared definitions for the sequential divider and the ALU/control decode
// that hands DIV operations to it.
package divider_seq_pkg;

    // Default operand width of the divider datapath.
    localparam int DEFAULT_WIDTH = 32;

    // Divider control states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ITER  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } div_state_e;

    // ALU operation indices, shared so the ALU and control decode agree.
    localparam int ALU_OP_W = 4;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_MULU = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_DIV  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_NOT  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SHL  = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_SHR  = 4'd11;
    localparam logic [ALU_OP_W-1:0] ALU_DEC  = 4'd12;
    localparam logic [ALU_OP_W-1:0] ALU_INC  = 4'd13;

    // True for the ALU operations that are routed through the divider.
    function automatic logic alu_op_uses_divider(input logic [ALU_OP_W-1:0] op);
        logic hit;
        if ((op == ALU_DIV) || (op == ALU_DIVU)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/divider_seq_if.sv
// Start/busy/done handshake and operand/result bus between the control
// unit (master) and the sequential divider (slave).
interface divider_seq_if
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );

endinterface

// File: rtl/divider_seq_div_step.sv
// One restoring shift-subtract iteration: shifts {R, Q} left by one,
// tries R - |M| and keeps the difference when it does not go negative.
module div_step
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    // The shifted remainder needs WIDTH+1 bits (it can reach 2*|M|-1), and
    // the trial carries one more bit so its sign is unambiguous.
    logic [WIDTH:0]   shifted_r_s;
    logic [WIDTH+1:0] trial_s;

    // Trial subtraction and restore decision for a single quotient bit.
    always_comb begin
        shifted_r_s = {r_in, q_in[WIDTH-1]};
        trial_s     = {1'b0, shifted_r_s} - {2'b00, m_in};
        // A successful trial is always below |M|, so both top bits are clear.
        if (trial_s[WIDTH+1:WIDTH] == 2'b00) begin
            r_out = trial_s[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            r_out = shifted_r_s[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle signed/unsigned integer divider: one quotient bit per clock,
// divide-by-zero flag, start/busy/done handshake. {remainder, quotient}
// maps directly onto HI/LO of the Z register path.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    divider_seq_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    // Magnitude of an operand; MIN maps onto 2^(WIDTH-1) as an unsigned value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = twos_neg(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic             accept_s;
    logic             divisor_zero_s;

    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic             signed_r;
    logic [WIDTH-1:0] rem_work_r;
    logic [WIDTH-1:0] quo_work_r;
    logic [WIDTH-1:0] mag_divisor_r;
    logic             q_neg_r;
    logic             r_neg_r;

    logic [WIDTH-1:0] step_rem_s;
    logic [WIDTH-1:0] step_quo_s;

    logic             busy_r;
    logic             done_r;
    logic             div_by_zero_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in  (rem_work_r),
        .q_in  (quo_work_r),
        .m_in  (mag_divisor_r),
        .r_out (step_rem_s),
        .q_out (step_quo_s)
    );

    // A new divide is accepted only while not busy (IDLE or the DONE cycle).
    always_comb begin
        accept_s       = 1'b0;
        divisor_zero_s = 1'b0;
        if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && bus.start) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (divisor_r == ZERO_W) begin
            divisor_zero_s = 1'b1;
        end else begin
            divisor_zero_s = 1'b0;
        end
    end

    // Next-state decode for the divide sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_next_s = ST_PREP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PREP: begin
                if (divisor_zero_s) begin
                    state_next_s = ST_FIXUP;
                end else begin
                    state_next_s = ST_ITER;
                end
            end
            ST_ITER: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_FIXUP;
                end else begin
                    state_next_s = ST_ITER;
                end
            end
            ST_FIXUP: begin
                state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any divide in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, magnitude prep, iteration and sign fixup datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r         <= CNT_ZERO;
            dividend_r    <= ZERO_W;
            divisor_r     <= ZERO_W;
            signed_r      <= 1'b0;
            rem_work_r    <= ZERO_W;
            quo_work_r    <= ZERO_W;
            mag_divisor_r <= ZERO_W;
            q_neg_r       <= 1'b0;
            r_neg_r       <= 1'b0;
            div_by_zero_r <= 1'b0;
            quotient_r    <= ZERO_W;
            remainder_r   <= ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        dividend_r    <= bus.dividend;
                        divisor_r     <= bus.divisor;
                        signed_r      <= bus.signed_mode;
                        div_by_zero_r <= 1'b0;
                    end
                end
                ST_PREP: begin
                    quo_work_r    <= magnitude(dividend_r, signed_r);
                    mag_divisor_r <= magnitude(divisor_r, signed_r);
                    rem_work_r    <= ZERO_W;
                    cnt_r         <= CNT_LAST;
                    q_neg_r       <= signed_r & (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]);
                    r_neg_r       <= signed_r & dividend_r[WIDTH-1];
                end
                ST_ITER: begin
                    rem_work_r <= step_rem_s;
                    quo_work_r <= step_quo_s;
                    cnt_r      <= cnt_r - CNT_ONE;
                end
                ST_FIXUP: begin
                    if (divisor_zero_s) begin
                        quotient_r    <= ONES_W;
                        remainder_r   <= dividend_r;
                        div_by_zero_r <= 1'b1;
                    end else begin
                        // MIN / -1 needs no special case: |MIN| / 1 with
                        // q_neg clear already yields the MIN bit pattern.
                        quotient_r    <= q_neg_r ? twos_neg(quo_work_r) : quo_work_r;
                        remainder_r   <= r_neg_r ? twos_neg(rem_work_r) : rem_work_r;
                        div_by_zero_r <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered handshake status derived from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_PREP) || (state_next_s == ST_ITER) ||
                      (state_next_s == ST_FIXUP);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = div_by_zero_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq at WIDTH = 32 and WIDTH = 8 against an
// arithmetic reference model.
module tb_divider_seq;

    typedef struct {
        longint unsigned q;
        longint unsigned r;
        bit              dbz;
        longint          due;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset32;
    logic   reset8;
    longint cyc = 0;
    int     errors = 0;
    int     checks = 0;
    exp_t   q32[$];
    exp_t   q8[$];
    exp_t   e32;
    exp_t   e8;

    divider_seq_if #(.WIDTH(32)) bus32 ();
    divider_seq_if #(.WIDTH(8))  bus8 ();

    divider_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset32), .bus(bus32.slave));
    divider_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset8),  .bus(bus8.slave));

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: truncating division on plain integers, sign-extended per width.
    function automatic void ref_div(input int w, input bit sm,
                                    input longint unsigned a, input longint unsigned b,
                                    output longint unsigned q, output longint unsigned r,
                                    output bit dbz);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint sa;
        longint sb;
        dbz = 1'b0;
        if (b == 0) begin
            q = mask; r = a; dbz = 1'b1;
        end else if (sm) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            q = longint'(sa / sb) & mask;
            r = longint'(sa % sb) & mask;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    function automatic bit get_done(input bit w8);
        return w8 ? bus8.done : bus32.done;
    endfunction

    function automatic bit get_busy(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction

    task automatic drive(input bit w8, input bit st, input bit sm,
                         input longint unsigned a, input longint unsigned b);
        if (w8) begin
            bus8.start = st; bus8.signed_mode = sm; bus8.dividend = a[7:0]; bus8.divisor = b[7:0];
        end else begin
            bus32.start = st; bus32.signed_mode = sm; bus32.dividend = a[31:0]; bus32.divisor = b[31:0];
        end
    endtask

    // Present one start for a cycle and queue its expected result.
    task automatic issue(input bit w8, input bit sm, input longint unsigned a, input longint unsigned b);
        exp_t e;
        int   w = w8 ? 8 : 32;
        ref_div(w, sm, a, b, e.q, e.r, e.dbz);
        e.due = cyc + ((b == 0) ? 3 : w + 3);
        drive(w8, 1'b1, sm, a, b);
        if (w8) q8.push_back(e); else q32.push_back(e);
        @(negedge clk);
        drive(w8, 1'b0, sm, a, b);
    endtask

    // Wait (bounded) for done, counting busy cycles on the way.
    task automatic wait_done(input bit w8, output int busy_cycles);
        int n = 0;
        busy_cycles = 0;
        while (!get_done(w8) && n < 200) begin
            if (get_busy(w8)) busy_cycles++;
            n++;
            @(negedge clk);
        end
        if (!get_done(w8)) chk(w8 ? "done_timeout8" : "done_timeout32", 0, 1);
    endtask

    task automatic run(input bit w8, input bit sm, input longint unsigned a, input longint unsigned b);
        int bc;
        issue(w8, sm, a, b);
        wait_done(w8, bc);
        @(negedge clk);
    endtask

    // Monitor for the 32-bit divider: compare each done against the queue.
    always @(negedge clk) begin
        if (bus32.done) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", 1, 0);
            end else begin
                e32 = q32.pop_front();
                chk("quotient32", bus32.quotient, e32.q);
                chk("remainder32", bus32.remainder, e32.r);
                chk("dbz32", bus32.div_by_zero, e32.dbz);
                chk("latency32", cyc, e32.due);
            end
        end
    end

    // Monitor for the 8-bit divider.
    always @(negedge clk) begin
        if (bus8.done) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 1, 0);
            end else begin
                e8 = q8.pop_front();
                chk("quotient8", bus8.quotient, e8.q);
                chk("remainder8", bus8.remainder, e8.r);
                chk("dbz8", bus8.div_by_zero, e8.dbz);
                chk("latency8", cyc, e8.due);
            end
        end
    end

    // Hard time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Directed and random stimulus.
    initial begin
        int bc;
        int done_seen;
        longint unsigned a;
        longint unsigned b;
        bit sm;

        drive(1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        reset32 = 1'b1;
        reset8  = 1'b1;
        repeat (3) @(negedge clk);
        reset32 = 1'b0;
        reset8  = 1'b0;

        chk("rst_busy32", bus32.busy, 0);
        chk("rst_done32", bus32.done, 0);
        chk("rst_dbz32", bus32.div_by_zero, 0);
        chk("rst_q32", bus32.quotient, 0);
        chk("rst_r32", bus32.remainder, 0);
        chk("rst_busy8", bus8.busy, 0);
        chk("rst_q8", bus8.quotient, 0);
        chk("rst_r8", bus8.remainder, 0);

        // 20 / 5 with busy-length check.
        issue(1'b0, 1'b0, 20, 5);
        wait_done(1'b0, bc);
        chk("busy_cycles_20_5", bc, 34);
        @(negedge clk);

        run(1'b0, 1'b1, 64'hFFFF_FFF9, 2);
        run(1'b0, 1'b1, 7, 64'hFFFF_FFFE);
        run(1'b0, 1'b1, 64'hFFFF_FFF9, 64'hFFFF_FFFE);
        run(1'b0, 1'b0, 64'hFFFF_FFF9, 2);

        // Divide by zero: short path.
        issue(1'b0, 1'b0, 13, 0);
        wait_done(1'b0, bc);
        chk("busy_cycles_dbz", bc, 2);
        @(negedge clk);

        run(1'b0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);

        // Start mid-ITER must be ignored.
        issue(1'b0, 1'b0, 1000, 7);
        repeat (10) @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 99, 3);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 99, 3);
        wait_done(1'b0, bc);
        @(negedge clk);
        chk("ignored_start_busy", bus32.busy, 0);

        // Back-to-back: start issued in the done cycle.
        issue(1'b0, 1'b0, 100, 9);
        wait_done(1'b0, bc);
        issue(1'b0, 1'b1, 64'hFFFF_FF9C, 9);
        wait_done(1'b0, bc);
        @(negedge clk);

        // WIDTH = 8.
        run(1'b1, 1'b0, 200, 7);
        run(1'b1, 1'b1, 8'h80, 8'hFF);
        run(1'b1, 1'b1, 8'hF9, 2);
        run(1'b1, 1'b0, 8'h5A, 0);

        // Random operands, biased toward edge values.
        for (int i = 0; i < 40; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = (($urandom_range(0, 9) == 0) ? 64'h8000_0000 : 64'($urandom));
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = 64'hFFFF_FFFF;
                2:       b = 64'($urandom_range(1, 15));
                default: b = 64'($urandom);
            endcase
            run(1'b0, sm, a, b);
        end
        for (int i = 0; i < 40; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = 64'($urandom_range(0, 255));
            case ($urandom_range(0, 5))
                0:       b = 0;
                1:       b = 64'hFF;
                default: b = 64'($urandom_range(0, 255));
            endcase
            run(1'b1, sm, a, b);
        end

        // Establish a known nonzero result, then abort a divide with reset.
        run(1'b0, 1'b0, 77, 5);
        drive(1'b0, 1'b1, 1'b0, 12345, 7);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 12345, 7);
        repeat (10) @(negedge clk);
        reset32 = 1'b1;
        @(negedge clk);
        reset32 = 1'b0;
        chk("abort_busy", bus32.busy, 0);
        chk("abort_done", bus32.done, 0);
        chk("abort_dbz", bus32.div_by_zero, 0);
        chk("abort_q", bus32.quotient, 0);
        chk("abort_r", bus32.remainder, 0);
        done_seen = 0;
        repeat (60) begin
            if (bus32.done) done_seen++;
            @(negedge clk);
        end
        chk("abort_no_done", done_seen, 0);

        run(1'b0, 1'b0, 20, 5);

        chk("queue32_drained", q32.size(), 0);
        chk("queue8_drained", q8.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
